set_err_monitor: RTL and testbench

Aggregates the per-channel single-event-transient error flags produced by the dual-clock comb-logic detectors and turns them into software-visible state. It keeps a saturating error counter and a sticky flag per channel, and a windowed burst detector across all channels. It raises a one-cycle interrupt on new events. The block sits directly downstream of the detector array, in the `clk_i` domain.

---
 rtl/set_mon_pkg.sv | 58 +++++
 rtl/set_ch_counter.sv | 62 ++++++
 rtl/set_err_monitor.sv | 138 +++++++++++++
 tb/tb_set_err_monitor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_mon_pkg.sv
// -----------------------------------------------------------------------------
// set_mon_pkg
// Shared definitions for the SET error monitor:
//   - default parameter values for the monitor and its channel counters
//   - popcount over a MAX_W-bit vector
//   - saturating increment / saturating add limited to a runtime width
// Operands are carried at MAX_W bits; callers zero-extend on the way in and
// truncate on the way out, so every width up to MAX_W is covered.
// -----------------------------------------------------------------------------
package set_mon_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_WIN_W = 16;
    localparam int DEF_THR_W = 8;
    localparam int MAX_W     = 32;

    localparam logic [MAX_W-1:0] ONE_W = 1;

    // Number of set bits in v.
    function automatic logic [MAX_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [MAX_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {{(MAX_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // All-ones value of a w-bit field (2^w - 1), w <= MAX_W.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    // v + 1, held at 2^w - 1 instead of wrapping.
    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] lim;
        lim = sat_max(w);
        return (v >= lim) ? lim : v + ONE_W;
    endfunction

    // a + b, held at 2^w - 1 instead of wrapping.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int               w);
        logic [MAX_W-1:0] lim;
        logic [MAX_W:0]   s;
        lim = sat_max(w);
        s   = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/set_ch_counter.sv
// -----------------------------------------------------------------------------
// set_ch_counter
// One monitored channel: saturating error counter, sticky "error seen" bit and
// a combinational strobe marking the cycle in which the sticky bit is about
// to go 0->1.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   clr_i           clear counter and sticky bit (wins over err_i)
//   err_i           registered, already-masked error flag for this channel
//   cnt_o           saturating error count
//   sticky_o        error seen since last clear/reset
//   new_sticky_o    sticky bit sets on this edge (first error since clear)
// -----------------------------------------------------------------------------
module set_ch_counter
    import set_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             err_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o,
    output logic             new_sticky_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps always_comb from inferring a latch.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (err_i) begin
            cnt_d    = CNT_W'(sat_inc(MAX_W'(cnt_q), CNT_W));
            sticky_d = 1'b1;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign sticky_o     = sticky_q;
    // A clear in the same cycle discards the error, so it cannot interrupt.
    assign new_sticky_o = err_i & ~sticky_q & ~clr_i;

endmodule

// File: rtl/set_err_monitor.sv
// -----------------------------------------------------------------------------
// set_err_monitor
// Aggregates per-channel single-event-transient error flags into per-channel
// saturating counters and sticky flags, a windowed burst alarm across all
// channels, and a one-cycle interrupt on new sticky bits or a new burst.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   en_i            monitor enable (errors ignored, window timer holds)
//   mask_i          per-channel ignore mask
//   error_i         per-channel detector flags, level per cycle
//   clr_i           clear counters, sticky flags, burst and window
//   win_len_i       window length in cycles, 0 disables windowing
//   thr_i           burst threshold, 0 disables burst detection
//   rd_ch_i         channel selected for count readout
//   rd_cnt_o        registered count of rd_ch_i (0 for out-of-range channel)
//   sticky_o        per-channel error-seen flags
//   burst_o         sticky burst alarm
//   irq_o           one-cycle interrupt
// -----------------------------------------------------------------------------
module set_err_monitor
    import set_mon_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    parameter  int CNT_W = DEF_CNT_W,
    parameter  int WIN_W = DEF_WIN_W,
    parameter  int THR_W = DEF_THR_W,
    localparam int RD_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N_CH-1:0]  mask_i,
    input  logic [N_CH-1:0]  error_i,
    input  logic             clr_i,
    input  logic [WIN_W-1:0] win_len_i,
    input  logic [THR_W-1:0] thr_i,
    input  logic [RD_W-1:0]  rd_ch_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [N_CH-1:0]  sticky_o,
    output logic             burst_o,
    output logic             irq_o
);

    // Registered, masked error flags; every decision below is taken on these.
    logic [N_CH-1:0]  s1_q, s1_d;
    logic [WIN_W-1:0] win_t_q, win_t_d;
    logic [THR_W-1:0] win_sum_q, win_sum_d;
    logic             burst_q, burst_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  new_sticky;

    logic             wrap;
    logic [THR_W-1:0] sum_sat;
    logic             burst_hit;

    // ---------------------------------------------------------------- channels
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        set_ch_counter #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .clr_i        (clr_i),
            .err_i        (s1_q[g]),
            .cnt_o        (cnt[g]),
            .sticky_o     (sticky_o[g]),
            .new_sticky_o (new_sticky[g])
        );
    end

    // ------------------------------------------------------- window and burst
    always_comb begin
        s1_d = en_i ? (error_i & ~mask_i) : '0;

        // A length shrunk below the current position wraps on the next edge.
        wrap = (win_len_i != '0) && (win_t_q >= win_len_i - WIN_W'(1));

        // The wrap-cycle errors join the compare before the sum restarts.
        sum_sat   = THR_W'(sat_add(MAX_W'(win_sum_q), popcount(MAX_W'(s1_q)), THR_W));
        burst_hit = (thr_i != '0) && (sum_sat >= thr_i);

        win_t_d   = win_t_q;
        win_sum_d = sum_sat;
        if (en_i) begin
            if (win_len_i == '0 || wrap) begin
                win_t_d = '0;
            end else begin
                win_t_d = win_t_q + WIN_W'(1);
            end
            if (wrap) win_sum_d = '0;
        end

        burst_d = burst_q | burst_hit;
        irq_d   = (|new_sticky) | (burst_hit & ~burst_q);

        // Clear discards the s1 consumed on this edge; s1_d still captures.
        if (clr_i) begin
            win_t_d   = '0;
            win_sum_d = '0;
            burst_d   = 1'b0;
            irq_d     = 1'b0;
        end
    end

    // --------------------------------------------------------------- readout
    always_comb begin
        rd_cnt_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (32'(rd_ch_i) == i) rd_cnt_d = cnt[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= '0;
            win_t_q   <= '0;
            win_sum_q <= '0;
            burst_q   <= 1'b0;
            irq_q     <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            s1_q      <= s1_d;
            win_t_q   <= win_t_d;
            win_sum_q <= win_sum_d;
            burst_q   <= burst_d;
            irq_q     <= irq_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign burst_o  = burst_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_set_err_monitor.sv
// -----------------------------------------------------------------------------
// tb_set_err_monitor
// Directed stimulus for set_err_monitor (N_CH=4, CNT_W=4). Each stimulus step
// pushes hand-computed expectations tagged with the clock edge after which
// they must hold; a monitor pops and compares them 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_set_err_monitor;

    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int THR_W = 8;

    localparam int F_STICKY = 0;
    localparam int F_BURST  = 1;
    localparam int F_IRQ    = 2;
    localparam int F_RD     = 3;
    localparam int F_WINT   = 4;

    typedef struct {
        int          at;
        int          fld;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic             rst;
        logic             en;
        logic             clr;
        logic [N_CH-1:0]  mask;
        logic [N_CH-1:0]  err;
        logic [WIN_W-1:0] win_len;
        logic [THR_W-1:0] thr;
        logic [1:0]       rd_ch;
    } drv_t;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             en_i;
    logic [N_CH-1:0]  mask_i;
    logic [N_CH-1:0]  error_i;
    logic             clr_i;
    logic [WIN_W-1:0] win_len_i;
    logic [THR_W-1:0] thr_i;
    logic [1:0]       rd_ch_i;
    logic [CNT_W-1:0] rd_cnt_o;
    logic [N_CH-1:0]  sticky_o;
    logic             burst_o;
    logic             irq_o;

    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    exp_t exp_q[$];
    drv_t d;

    set_err_monitor #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W),
        .THR_W (THR_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .mask_i    (mask_i),
        .error_i   (error_i),
        .clr_i     (clr_i),
        .win_len_i (win_len_i),
        .thr_i     (thr_i),
        .rd_ch_i   (rd_ch_i),
        .rd_cnt_o  (rd_cnt_o),
        .sticky_o  (sticky_o),
        .burst_o   (burst_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [31:0] act_of(input int fld);
        case (fld)
            F_STICKY: return 32'(sticky_o);
            F_BURST:  return 32'(burst_o);
            F_IRQ:    return 32'(irq_o);
            F_RD:     return 32'(rd_cnt_o);
            default:  return 32'(dut.win_t_q);
        endcase
    endfunction

    task automatic push(input int at, input int fld, input logic [31:0] val, input string name);
        exp_t e;
        e.at   = at;
        e.fld  = fld;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic apply();
        rst_i     = d.rst;
        en_i      = d.en;
        clr_i     = d.clr;
        mask_i    = d.mask;
        error_i   = d.err;
        win_len_i = d.win_len;
        thr_i     = d.thr;
        rd_ch_i   = d.rd_ch;
    endtask

    // Drive d for the next edge; k returns that edge's number. clr is a pulse.
    task automatic tick(output int k);
        @(negedge clk);
        apply();
        k     = edge_cnt + 1;
        d.clr = 1'b0;
    endtask

    task automatic idle(input int n);
        int k;
        for (int i = 0; i < n; i++) tick(k);
    endtask

    // Monitor: compare every expectation due at the edge just taken.
    always @(posedge clk) begin
        int i;
        #1;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].at <= edge_cnt) begin
                check(exp_q[i].name, act_of(exp_q[i].fld), exp_q[i].val);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, kc, kr;

        d = '{rst: 1'b1, en: 1'b0, clr: 1'b0, mask: '0, err: '0,
              win_len: '0, thr: '0, rd_ch: '0};
        apply();

        // ---- reset
        idle(1);
        tick(k);
        push(k, F_STICKY, 0, "reset_sticky");
        push(k, F_BURST,  0, "reset_burst");
        push(k, F_IRQ,    0, "reset_irq");
        push(k, F_RD,     0, "reset_rd_cnt");
        push(k, F_WINT,   0, "reset_win_t");
        d.rst = 1'b0;
        d.en  = 1'b1;

        // ---- single error, then a repeat on the now-sticky channel
        d.err = 4'b0001;
        tick(k);
        push(k+1, F_STICKY, 4'b0001, "single_sticky");
        push(k+1, F_IRQ,    1,       "single_irq");
        push(k+1, F_RD,     0,       "single_rd_latency");
        push(k+2, F_IRQ,    0,       "single_irq_one_cycle");
        push(k+2, F_RD,     1,       "single_rd_cnt1");
        d.err = '0;
        idle(2);
        d.err = 4'b0001;
        tick(k);
        push(k+1, F_IRQ, 0, "repeat_no_irq");
        push(k+2, F_RD,  2, "repeat_rd_cnt2");
        d.err = '0;
        idle(2);

        // ---- saturation of channel 2
        d.rd_ch = 2'd2;
        d.clr   = 1'b1;
        tick(k);
        push(k,   F_STICKY, 0, "clr_sticky");
        push(k+1, F_RD,     0, "clr_rd_cnt");
        d.err = 4'b0100;
        for (int t = 0; t < 20; t++) begin
            tick(k);
            if (t == 0) begin
                push(k+1, F_STICKY, 4'b0100, "sat_sticky");
                push(k+1, F_IRQ,    1,       "sat_irq");
            end
            if (t == 9)  push(k+1, F_RD, 9,  "sat_cnt9");
            if (t == 15) push(k+1, F_RD, 15, "sat_cnt15");
            if (t == 16) push(k+1, F_RD, 15, "sat_no_wrap");
            if (t == 19) push(k+2, F_RD, 15, "sat_hold");
        end
        d.err = '0;
        idle(2);

        // ---- burst: 2+2 errors inside one 8-cycle window, threshold 3
        d.win_len = 16'd8;
        d.thr     = 8'd3;
        d.clr     = 1'b1;
        tick(k);
        push(k, F_BURST, 0, "clr_burst");
        d.err = 4'b0011;
        tick(k);
        push(k+1, F_BURST, 0, "burst_sum2");
        push(k+1, F_IRQ,   1, "burst_sticky_irq");
        tick(k);
        push(k+1, F_BURST, 1, "burst_sum4");
        push(k+1, F_IRQ,   1, "burst_irq");
        push(k+2, F_IRQ,   0, "burst_irq_once");
        push(k+2, F_BURST, 1, "burst_sticky");
        d.err = '0;
        idle(2);

        // ---- same 3 errors split 2|1 across the window wrap: no burst
        d.clr = 1'b1;
        tick(kc);
        push(kc+7,  F_WINT,  7, "spread_win_t7");
        push(kc+8,  F_WINT,  0, "spread_wrap");
        push(kc+8,  F_BURST, 0, "spread_w1");
        push(kc+9,  F_BURST, 0, "spread_w2");
        push(kc+10, F_BURST, 0, "spread_after");
        for (int t = 1; t <= 8; t++) begin
            d.err = (t == 7) ? 4'b0011 : (t == 8) ? 4'b0001 : 4'b0000;
            tick(k);
        end
        d.err = '0;
        idle(3);

        // ---- masking, then enable low freezes everything
        d.thr   = 8'd0;
        d.rd_ch = 2'd1;
        d.clr   = 1'b1;
        tick(kc);
        push(kc+2, F_STICKY, 0, "mask_sticky");
        push(kc+2, F_IRQ,    0, "mask_irq");
        push(kc+3, F_RD,     0, "mask_cnt");
        push(kc+5, F_WINT,   2, "en_low_win_t_frozen");
        push(kc+6, F_STICKY, 0, "en_low_sticky");
        push(kc+6, F_IRQ,    0, "en_low_irq");
        push(kc+6, F_WINT,   3, "en_win_t_resumes");
        push(kc+7, F_RD,     0, "en_low_cnt");
        d.mask = 4'b0010;
        d.err  = 4'b0010;
        tick(k);
        d.mask = '0;
        d.err  = '0;
        tick(k);
        d.en  = 1'b0;
        d.err = 4'b1111;
        idle(3);
        d.en  = 1'b1;
        d.err = '0;
        idle(3);

        // ---- clear collides with errors at edges k-1 and k
        d.err = 4'b0010;
        tick(k);
        d.clr = 1'b1;
        tick(k);
        push(k,   F_STICKY, 0,       "coll_clr_sticky");
        push(k,   F_IRQ,    0,       "coll_clr_irq");
        push(k+1, F_STICKY, 4'b0010, "coll_sticky");
        push(k+1, F_IRQ,    1,       "coll_irq");
        push(k+2, F_RD,     1,       "coll_cnt1");
        d.err = '0;
        idle(3);

        // ---- reset while win_sum=2 and burst=1
        d.thr = 8'd2;
        d.clr = 1'b1;
        tick(kc);
        d.err = 4'b0011;
        tick(k);
        push(kc+2, F_BURST, 1, "pre_reset_burst");
        d.err = '0;
        tick(k);
        d.rst = 1'b1;
        tick(kr);
        push(kr,   F_STICKY, 0, "rst_mid_sticky");
        push(kr,   F_BURST,  0, "rst_mid_burst");
        push(kr,   F_IRQ,    0, "rst_mid_irq");
        push(kr,   F_RD,     0, "rst_mid_rd_cnt");
        push(kr,   F_WINT,   0, "rst_mid_win_t");
        push(kr+1, F_WINT,   1, "rst_win_restart");
        push(kr+2, F_BURST,  0, "rst_no_stale_sum");
        push(kr+2, F_IRQ,    0, "rst_no_irq");
        d.rst = 1'b0;
        idle(4);

        // Anything still queued was never compared.
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no comparison, expected one at edge %0d",
                     exp_q[0].name, exp_q[0].at);
            void'(exp_q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
